// File: rtl/lfsr_scan_display.sv
// Pseudo-random display engine: Fibonacci LFSR stepped by prescaler tick (run) or step edge (pause),
// with the top nibbles multiplexed onto one seven-segment bus. Optional load port: LFSR_SCAN_LOAD_EN.
module lfsr_scan_display #(
    parameter int                 width_p      = 11,
    parameter logic [width_p-1:0] taps_p       = 11'h500,
    parameter logic [width_p-1:0] seed_p       = {{(width_p-1){1'b0}}, 1'b1},
    parameter int                 tick_width_p = 22,
    parameter int                 digits_p     = 2,
    parameter int                 scan_width_p = 14
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                run_i,
    input  logic                step_i,
`ifdef LFSR_SCAN_LOAD_EN
    input  logic                load_i,
    input  logic [width_p-1:0]  load_data_i,
`endif
    output logic [width_p-1:0]  data_o,
    output logic                adv_o,
    output logic                tick_o,
    output logic [6:0]          seg_o,
    output logic [digits_p-1:0] dig_o
);

    localparam int idx_w_lp = (digits_p > 1) ? $clog2(digits_p) : 1;
    localparam int win_lo_lp = width_p - 4 * digits_p;

    logic [tick_width_p-1:0] tick_cnt_r;
    logic [scan_width_p-1:0] scan_cnt_r;
    logic [idx_w_lp-1:0]     dig_idx_r;
    logic [idx_w_lp-1:0]     dig_idx_next_s;
    logic [digits_p-1:0]     dig_r;
    logic [width_p-1:0]      data_r;
    logic [width_p-1:0]      data_next_s;
    logic                    adv_r;
    logic                    adv_s;
    logic                    step_q_r;
    logic                    tick_s;
    logic                    edge_s;
    logic [3:0]              nibble_s;

    // Shift left and append tap parity; a zero state can only recover via the seed.
    function automatic logic [width_p-1:0] lfsr_next(input logic [width_p-1:0] d);
        if (d == {width_p{1'b0}}) begin
            lfsr_next = seed_p;
        end else begin
            lfsr_next = {d[width_p-2:0], ^(d & taps_p)};
        end
    endfunction

    // Segment pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex2ssd(input logic [3:0] h);
        case (h)
            4'h0:    hex2ssd = 7'b1000000;
            4'h1:    hex2ssd = 7'b1111001;
            4'h2:    hex2ssd = 7'b0100100;
            4'h3:    hex2ssd = 7'b0110000;
            4'h4:    hex2ssd = 7'b0011001;
            4'h5:    hex2ssd = 7'b0010010;
            4'h6:    hex2ssd = 7'b0000010;
            4'h7:    hex2ssd = 7'b1111000;
            4'h8:    hex2ssd = 7'b0000000;
            4'h9:    hex2ssd = 7'b0010000;
            4'hA:    hex2ssd = 7'b0001000;
            4'hB:    hex2ssd = 7'b0000011;
            4'hC:    hex2ssd = 7'b1000110;
            4'hD:    hex2ssd = 7'b0100001;
            4'hE:    hex2ssd = 7'b0000110;
            4'hF:    hex2ssd = 7'b0001110;
            default: hex2ssd = 7'b1111111;
        endcase
    endfunction

    assign tick_s = &tick_cnt_r;
    assign edge_s = step_i & ~step_q_r;

    // Advance decision and next LFSR value; a load overrides any advance.
    always_comb begin
        adv_s       = run_i ? tick_s : edge_s;
        data_next_s = data_r;
`ifdef LFSR_SCAN_LOAD_EN
        if (load_i) begin
            adv_s       = 1'b1;
            data_next_s = (load_data_i == {width_p{1'b0}}) ? seed_p : load_data_i;
        end else if (adv_s) begin
            data_next_s = lfsr_next(data_r);
        end else begin
            data_next_s = data_r;
        end
`else
        if (adv_s) begin
            data_next_s = lfsr_next(data_r);
        end else begin
            data_next_s = data_r;
        end
`endif
    end

    // LFSR state, advance pulse, step-edge history and free-running prescaler.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_r     <= seed_p;
            adv_r      <= 1'b0;
            step_q_r   <= 1'b0;
            tick_cnt_r <= {tick_width_p{1'b0}};
        end else begin
            data_r     <= data_next_s;
            adv_r      <= adv_s;
            step_q_r   <= step_i;
            tick_cnt_r <= tick_cnt_r + {{(tick_width_p-1){1'b0}}, 1'b1};
        end
    end

    // Next digit index: steps when the scan counter is about to wrap.
    always_comb begin
        dig_idx_next_s = dig_idx_r;
        if (&scan_cnt_r) begin
            if (dig_idx_r == idx_w_lp'(digits_p - 1)) begin
                dig_idx_next_s = {idx_w_lp{1'b0}};
            end else begin
                dig_idx_next_s = dig_idx_r + {{(idx_w_lp-1){1'b0}}, 1'b1};
            end
        end else begin
            dig_idx_next_s = dig_idx_r;
        end
    end

    // Scan counter, digit index and its one-hot select, kept in lockstep.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            scan_cnt_r <= {scan_width_p{1'b0}};
            dig_idx_r  <= {idx_w_lp{1'b0}};
            dig_r      <= {{(digits_p-1){1'b0}}, 1'b1};
        end else begin
            scan_cnt_r <= scan_cnt_r + {{(scan_width_p-1){1'b0}}, 1'b1};
            dig_idx_r  <= dig_idx_next_s;
            dig_r      <= {{(digits_p-1){1'b0}}, 1'b1} << dig_idx_next_s;
        end
    end

    // Pick the window nibble for the selected digit.
    always_comb begin
        nibble_s = 4'h0;
        for (int k = 0; k < digits_p; k++) begin
            if (dig_idx_r == idx_w_lp'(k)) begin
                nibble_s = data_r[win_lo_lp + 4*k +: 4];
            end else begin
                nibble_s = nibble_s;
            end
        end
    end

    assign data_o = data_r;
    assign adv_o  = adv_r;
    assign tick_o = tick_s;
    assign dig_o  = dig_r;
    assign seg_o  = hex2ssd(nibble_s);

endmodule

// File: tb/tb_lfsr_scan_display.sv
// Self-checking bench for lfsr_scan_display with a cycle-count based reference model.
// Load tests are compiled in only when LFSR_SCAN_LOAD_EN is defined.
module tb_lfsr_scan_display;

    localparam int W      = 11;
    localparam int DIG    = 2;
    localparam int TW     = 4;
    localparam int SW     = 3;
    localparam int TICK_P = 1 << TW;
    localparam int SCAN_P = 1 << SW;
    localparam logic [W-1:0] TAPS = 11'h500;
    localparam logic [W-1:0] SEED = 11'h001;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           run_i = 1'b0;
    logic           step_i = 1'b0;
    logic [W-1:0]   data_o;
    logic           adv_o;
    logic           tick_o;
    logic [6:0]     seg_o;
    logic [DIG-1:0] dig_o;
`ifdef LFSR_SCAN_LOAD_EN
    logic           load_i = 1'b0;
    logic [W-1:0]   load_data_i = '0;
`endif

    int n_err = 0;
    int n_chk = 0;

    // reference model state
    logic [W-1:0] m_data;
    logic         m_adv;
    logic         m_step_prev;
    int           m_cyc;
    logic [6:0]   ssd_tab [0:15];

    always #5 clk = ~clk;

    lfsr_scan_display #(
        .width_p(W), .taps_p(TAPS), .seed_p(SEED),
        .tick_width_p(TW), .digits_p(DIG), .scan_width_p(SW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .run_i(run_i), .step_i(step_i),
`ifdef LFSR_SCAN_LOAD_EN
        .load_i(load_i), .load_data_i(load_data_i),
`endif
        .data_o(data_o), .adv_o(adv_o), .tick_o(tick_o), .seg_o(seg_o), .dig_o(dig_o)
    );

    function automatic logic [W-1:0] ref_next(input logic [W-1:0] d);
        logic fb;
        fb = 1'b0;
        if (d == '0) return SEED;
        for (int i = 0; i < W; i++) if (TAPS[i]) fb = fb ^ d[i];
        return {d[W-2:0], fb};
    endfunction

    function automatic int exp_idx(input int cyc);
        return (cyc / SCAN_P) % DIG;
    endfunction

    function automatic logic [6:0] exp_seg(input int cyc, input logic [W-1:0] d);
        int sh;
        sh = W - 4*DIG + 4*exp_idx(cyc);
        return ssd_tab[(d >> sh) & 4'hF];
    endfunction

    function automatic logic exp_tick(input int cyc);
        return (cyc % TICK_P) == (TICK_P - 1);
    endfunction

    task automatic model_reset();
        m_data = SEED; m_adv = 1'b0; m_step_prev = 1'b0; m_cyc = 0;
    endtask

    // Evaluate the cycle with the current inputs, then move to just after the closing edge.
    task automatic advance_cycle();
        logic adv;
        adv = run_i ? exp_tick(m_cyc) : (step_i & ~m_step_prev);
`ifdef LFSR_SCAN_LOAD_EN
        if (load_i) begin
            adv = 1'b1;
            m_data = (load_data_i == '0) ? SEED : load_data_i;
        end else if (adv) m_data = ref_next(m_data);
`else
        if (adv) m_data = ref_next(m_data);
`endif
        m_adv = adv;
        m_step_prev = step_i;
        m_cyc++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        step_i = 1'b0;
        run_i  = 1'b0;
`ifdef LFSR_SCAN_LOAD_EN
        load_i = 1'b0;
`endif
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (data_o !== 11'h001) begin n_err++; $display("FAIL reset_data: got %h expected 001", data_o); end
        n_chk++; if (dig_o !== 2'b01) begin n_err++; $display("FAIL reset_dig: got %b expected 01", dig_o); end
        n_chk++; if (adv_o !== 1'b0) begin n_err++; $display("FAIL reset_adv: got %b expected 0", adv_o); end
        n_chk++; if (tick_o !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", tick_o); end
        n_chk++; if (seg_o !== ssd_tab[0]) begin n_err++; $display("FAIL reset_seg: got %b expected %b", seg_o, ssd_tab[0]); end
    endtask

    task automatic test_step();
        logic [W-1:0] want [3];
        int advs;
        want[0] = 11'h002; want[1] = 11'h004; want[2] = 11'h008;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            step_i = 1'b1; advance_cycle();
            n_chk++; if (data_o !== want[p] || adv_o !== 1'b1) begin
                n_err++; $display("FAIL step_pulse%0d: got %h adv %b expected %h adv 1", p, data_o, adv_o, want[p]);
            end
            step_i = 1'b0; advance_cycle();
            n_chk++; if (adv_o !== 1'b0 || data_o !== want[p]) begin
                n_err++; $display("FAIL step_idle%0d: got %h adv %b expected %h adv 0", p, data_o, adv_o, want[p]);
            end
            advance_cycle();
        end
        advs = 0;
        step_i = 1'b1;
        for (int c = 0; c < 10; c++) begin advance_cycle(); if (adv_o) advs++; end
        step_i = 1'b0; advance_cycle(); if (adv_o) advs++;
        n_chk++; if (advs != 1) begin n_err++; $display("FAIL step_held: got %0d advances expected 1", advs); end
        n_chk++; if (data_o !== 11'h010) begin n_err++; $display("FAIL step_held_data: got %h expected 010", data_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int s = 0; s < 8; s++) begin
            step_i = 1'b1; advance_cycle();
            step_i = 1'b0; advance_cycle();
        end
        n_chk++; if (data_o !== 11'h100) begin n_err++; $display("FAIL wrap_8steps: got %h expected 100", data_o); end
        step_i = 1'b1; advance_cycle(); step_i = 1'b0;
        n_chk++; if (data_o !== 11'h201) begin n_err++; $display("FAIL wrap_feedback: got %h expected 201", data_o); end
        advance_cycle();
    endtask

    task automatic test_run();
        int advs, first_adv, tick_bad, data_bad;
        bit done;
        advs = 0; first_adv = -1; tick_bad = 0; data_bad = 0; done = 0;
        do_reset();
        run_i = 1'b1;
        step_i = 1'b1;
        for (int c = 0; c < 2047*TICK_P + 64 && !done; c++) begin
            step_i = c[0];
            if (tick_o !== exp_tick(m_cyc)) tick_bad++;
            advance_cycle();
            if (data_o !== m_data || adv_o !== m_adv) data_bad++;
            if (adv_o) begin
                advs++;
                if (first_adv < 0) first_adv = m_cyc;
                if (data_o === SEED) done = 1;
            end
        end
        run_i = 1'b0; step_i = 1'b0;
        n_chk++; if (first_adv != 16) begin n_err++; $display("FAIL run_first_adv: got cycle %0d expected 16", first_adv); end
        n_chk++; if (advs != 2047 || !done) begin n_err++; $display("FAIL run_period: got %0d advances (returned %0d) expected 2047", advs, done); end
        n_chk++; if (tick_bad != 0) begin n_err++; $display("FAIL run_tick: got %0d bad cycles expected 0", tick_bad); end
        n_chk++; if (data_bad != 0) begin n_err++; $display("FAIL run_data: got %0d bad cycles expected 0", data_bad); end
    endtask

    task automatic test_scan();
        int toggles;
        logic [DIG-1:0] prev_dig;
        do_reset();
        for (int s = 0; s < 9; s++) begin
            step_i = 1'b1; advance_cycle();
            step_i = 1'b0; advance_cycle();
        end
        n_chk++; if (data_o !== 11'h201) begin n_err++; $display("FAIL scan_data: got %h expected 201", data_o); end
        toggles = 0; prev_dig = dig_o;
        for (int c = 0; c < 40; c++) begin
            n_chk++; if (dig_o !== DIG'(1 << exp_idx(m_cyc))) begin
                n_err++; $display("FAIL scan_dig c%0d: got %b expected %b", m_cyc, dig_o, DIG'(1 << exp_idx(m_cyc)));
            end
            n_chk++; if (seg_o !== ((dig_o == 2'b01) ? ssd_tab[0] : ssd_tab[4])) begin
                n_err++; $display("FAIL scan_seg c%0d: got %b for dig %b", m_cyc, seg_o, dig_o);
            end
            advance_cycle();
            if (dig_o !== prev_dig) toggles++;
            prev_dig = dig_o;
        end
        n_chk++; if (toggles != 5) begin n_err++; $display("FAIL scan_toggles: got %0d expected 5", toggles); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_i = 1'b1;
        while (m_cyc < 31) advance_cycle();
        n_chk++; if (tick_o !== 1'b1 || data_o !== 11'h002) begin
            n_err++; $display("FAIL mid_pre: got tick %b data %h expected tick 1 data 002", tick_o, data_o);
        end
        #2 reset_i = 1'b1;
        #1;
        n_chk++; if (data_o !== SEED || dig_o !== 2'b01 || adv_o !== 1'b0 || tick_o !== 1'b0 || seg_o !== ssd_tab[0]) begin
            n_err++; $display("FAIL mid_reset: got data %h dig %b adv %b tick %b seg %b expected 001 01 0 0 %b",
                data_o, dig_o, adv_o, tick_o, seg_o, ssd_tab[0]);
        end
        @(posedge clk); #1;
        n_chk++; if (data_o !== SEED || adv_o !== 1'b0) begin
            n_err++; $display("FAIL mid_no_adv: got data %h adv %b expected 001 0", data_o, adv_o);
        end
        reset_i = 1'b0; run_i = 1'b0;
        model_reset();
    endtask

`ifdef LFSR_SCAN_LOAD_EN
    task automatic test_load();
        do_reset();
        load_i = 1'b1; load_data_i = 11'h000; advance_cycle(); load_i = 1'b0;
        n_chk++; if (data_o !== SEED || adv_o !== 1'b1) begin
            n_err++; $display("FAIL load_zero: got %h adv %b expected 001 adv 1", data_o, adv_o);
        end
        load_i = 1'b1; load_data_i = 11'h155; step_i = 1'b1; advance_cycle();
        load_i = 1'b0; step_i = 1'b0;
        n_chk++; if (data_o !== 11'h155 || adv_o !== 1'b1) begin
            n_err++; $display("FAIL load_vs_step: got %h adv %b expected 155 adv 1", data_o, adv_o);
        end
        advance_cycle();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) run_i = ~run_i;
            step_i = ($urandom_range(0, 3) == 0);
`ifdef LFSR_SCAN_LOAD_EN
            load_i = ($urandom_range(0, 40) == 0);
            load_data_i = W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
`endif
            n_chk++; if (tick_o !== exp_tick(m_cyc)) begin
                n_err++; $display("FAIL rand_tick c%0d: got %b expected %b", m_cyc, tick_o, exp_tick(m_cyc));
            end
            advance_cycle();
            n_chk++; if (data_o !== m_data || adv_o !== m_adv) begin
                n_err++; $display("FAIL rand_data c%0d: got %h adv %b expected %h adv %b", m_cyc, data_o, adv_o, m_data, m_adv);
            end
            n_chk++; if (dig_o !== DIG'(1 << exp_idx(m_cyc)) || seg_o !== exp_seg(m_cyc, m_data)) begin
                n_err++; $display("FAIL rand_disp c%0d: got dig %b seg %b expected dig %b seg %b",
                    m_cyc, dig_o, seg_o, DIG'(1 << exp_idx(m_cyc)), exp_seg(m_cyc, m_data));
            end
        end
        run_i = 1'b0; step_i = 1'b0;
`ifdef LFSR_SCAN_LOAD_EN
        load_i = 1'b0;
`endif
    endtask

    initial begin
        ssd_tab[0]  = 7'b1000000; ssd_tab[1]  = 7'b1111001; ssd_tab[2]  = 7'b0100100; ssd_tab[3]  = 7'b0110000;
        ssd_tab[4]  = 7'b0011001; ssd_tab[5]  = 7'b0010010; ssd_tab[6]  = 7'b0000010; ssd_tab[7]  = 7'b1111000;
        ssd_tab[8]  = 7'b0000000; ssd_tab[9]  = 7'b0010000; ssd_tab[10] = 7'b0001000; ssd_tab[11] = 7'b0000011;
        ssd_tab[12] = 7'b1000110; ssd_tab[13] = 7'b0100001; ssd_tab[14] = 7'b0000110; ssd_tab[15] = 7'b0001110;
        model_reset();
        test_reset();
        test_step();
        test_wrap();
        test_run();
        test_scan();
        test_reset_mid();
`ifdef LFSR_SCAN_LOAD_EN
        test_load();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
